// File: rtl/fetch_pkg.sv
// Shared types for the fetch/decode decoupling queue.
package fetch_pkg;

    typedef struct packed {
        logic [63:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

    localparam logic [31:0] NOP_INSTR = 32'hD503201F;

endpackage

// File: rtl/fetchq_storage.sv
// DEPTH-entry register array: one synchronous write port, one asynchronous read port.
// Contents are never reset; validity is tracked by the pointers in the parent.
module fetchq_storage
    import fetch_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       wr_en_i,
    input  logic [$clog2(DEPTH)-1:0]   waddr_i,
    input  fetch_entry_t               wdata_i,
    input  logic [$clog2(DEPTH)-1:0]   raddr_i,
    output fetch_entry_t               rdata_o
);

    fetch_entry_t mem_q [DEPTH];

    // Write port
    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/instr_fetch_queue.sv
// Fetch-to-decode queue of {PC, instruction} pairs with flush and PC back-pressure.
// Optional zero-latency empty-queue bypass under INSTR_FETCH_QUEUE_BYPASS_EN.
module instr_fetch_queue
    import fetch_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [63:0]              in_pc,
    input  logic [31:0]              in_instr,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [63:0]              out_pc,
    output logic [31:0]              out_instr,
    input  logic                     flush,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     pc_hold
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_C = (AW+1)'(DEPTH);

    logic [AW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
    logic [AW:0]   count_q, count_d;
    fetch_entry_t  head_s, wdata_s;
    logic          empty_s, byp_s, push_s, pop_s, wr_en_s;

    fetchq_storage #(.DEPTH(DEPTH)) u_storage (
        .clk     (clk),
        .wr_en_i (wr_en_s),
        .waddr_i (wptr_q),
        .wdata_i (wdata_s),
        .raddr_i (rptr_q),
        .rdata_o (head_s)
    );

    // Handshake and output selection
    always_comb begin
        empty_s = (count_q == {(AW+1){1'b0}});
`ifdef INSTR_FETCH_QUEUE_BYPASS_EN
        byp_s   = empty_s && in_valid && !flush;
`else
        byp_s   = 1'b0;
`endif
        in_ready  = (count_q != FULL_C);
        pc_hold   = ~in_ready;
        out_valid = !empty_s || byp_s;
        if (byp_s) begin
            out_pc    = in_pc;
            out_instr = in_instr;
        end else if (!empty_s) begin
            out_pc    = head_s.pc;
            out_instr = head_s.instr;
        end else begin
            out_pc    = 64'h0;
            out_instr = NOP_INSTR;
        end
        push_s  = in_valid && in_ready;
        pop_s   = !empty_s && out_ready && reset && !flush;
        // A bypassed pair taken by decode the same cycle never enters storage.
        wr_en_s = push_s && reset && !flush && !(byp_s && out_ready);
        wdata_s = '{pc: in_pc, instr: in_instr};
    end

    // Pointer and occupancy next state
    always_comb begin
        if (flush) begin
            wptr_d  = {AW{1'b0}};
            rptr_d  = {AW{1'b0}};
            count_d = {(AW+1){1'b0}};
        end else begin
            wptr_d  = wptr_q + AW'(wr_en_s);
            rptr_d  = rptr_q + AW'(pop_s);
            count_d = count_q + (AW+1)'(wr_en_s) - (AW+1)'(pop_s);
        end
    end

    // State registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!reset) begin
            wptr_q  <= {AW{1'b0}};
            rptr_q  <= {AW{1'b0}};
            count_q <= {(AW+1){1'b0}};
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: tb/tb_instr_fetch_queue.sv
// Self-checking bench: directed test-plan sequences plus random traffic against a queue model.
module tb_instr_fetch_queue;

    localparam int DEPTH = 4;
    localparam logic [31:0] NOP = 32'hD503201F;

    logic        clk = 1'b0;
    logic        reset, in_valid, in_ready, out_valid, out_ready, flush, pc_hold;
    logic [63:0] in_pc, out_pc;
    logic [31:0] in_instr, out_instr;
    logic [$clog2(DEPTH):0] count;

    int chk_cnt  = 0;
    int pass_cnt = 0;
    logic [95:0] mq[$];

    instr_fetch_queue #(.DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_pc(in_pc), .in_instr(in_instr), .out_valid(out_valid), .out_ready(out_ready),
        .out_pc(out_pc), .out_instr(out_instr), .flush(flush), .count(count), .pc_hold(pc_hold)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        chk_cnt++;
        if (obs !== exp) $display("FAIL %s: got %h expected %h", tag, obs, exp);
        else pass_cnt++;
    endtask

    // One clock: drive inputs, check outputs against the model, advance model and DUT.
    task automatic step(input logic v, input logic [63:0] pc, input logic [31:0] ins,
                        input logic ordy, input logic fl, input logic rst);
        int   n;
        logic byp, e_valid, e_ready;
        logic [63:0] e_pc;
        logic [31:0] e_ins;
        @(negedge clk);
        in_valid = v; in_pc = pc; in_instr = ins; out_ready = ordy; flush = fl; reset = rst;
        #1;
        n = mq.size();
        e_ready = (n < DEPTH);
`ifdef INSTR_FETCH_QUEUE_BYPASS_EN
        byp = (n == 0) && v && !fl;
`else
        byp = 1'b0;
`endif
        e_valid = (n != 0) || byp;
        if (byp) begin
            e_pc = pc; e_ins = ins;
        end else if (n != 0) begin
            e_pc = mq[0][95:32]; e_ins = mq[0][31:0];
        end else begin
            e_pc = 64'h0; e_ins = NOP;
        end
        check_eq("count",     64'(count),     64'(n));
        check_eq("in_ready",  64'(in_ready),  64'(e_ready));
        check_eq("pc_hold",   64'(pc_hold),   64'(!e_ready));
        check_eq("out_valid", 64'(out_valid), 64'(e_valid));
        check_eq("out_pc",    out_pc,         e_pc);
        check_eq("out_instr", 64'(out_instr), 64'(e_ins));
        if (!rst || fl) begin
            mq.delete();
        end else if (byp && ordy) begin
            // consumed straight through
        end else begin
            if (e_valid && ordy) void'(mq.pop_front());
            if (v && e_ready) mq.push_back({pc, ins});
        end
        @(posedge clk);
    endtask

    initial begin
        reset = 1'b0; in_valid = 1'b0; in_pc = 64'h0; in_instr = 32'h0;
        out_ready = 1'b0; flush = 1'b0;
        repeat (2) @(posedge clk);

        // Fill to full, then a fifth push that must be refused
        for (int i = 0; i < 5; i++) step(1'b1, 64'(4*i), 32'h8B000000 + 32'(i), 1'b0, 1'b0, 1'b1);
        // Drain
        for (int i = 0; i < 5; i++) step(1'b0, 64'h0, 32'h0, 1'b1, 1'b0, 1'b1);
        // Streaming push+pop across pointer wrap
        for (int i = 0; i < 10; i++) step(1'b1, 64'h100 + 64'(4*i), 32'hF8400000 + 32'(i), 1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 2; i++) step(1'b0, 64'h0, 32'h0, 1'b1, 1'b0, 1'b1);
        // Flush with a concurrent push
        for (int i = 0; i < 3; i++) step(1'b1, 64'h20 + 64'(4*i), 32'h91000000 + 32'(i), 1'b0, 1'b0, 1'b1);
        step(1'b1, 64'h40, 32'h12345678, 1'b1, 1'b1, 1'b1);
        step(1'b0, 64'h0, 32'h0, 1'b1, 1'b0, 1'b1);
        // Mid-operation reset, then a fresh push
        for (int i = 0; i < 2; i++) step(1'b1, 64'h80 + 64'(4*i), 32'hAA000000 + 32'(i), 1'b0, 1'b0, 1'b1);
        step(1'b0, 64'h0, 32'h0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 64'h200, 32'hB4000000, 1'b1, 1'b0, 1'b1);
        step(1'b0, 64'h0, 32'h0, 1'b1, 1'b0, 1'b1);
        // Random traffic
        for (int i = 0; i < 400; i++) begin
            step($urandom_range(0, 3) != 0, {$urandom, $urandom}, $urandom,
                 $urandom_range(0, 1) == 1, $urandom_range(0, 19) == 0, $urandom_range(0, 49) != 0);
        end

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule

// File: doc/instr_fetch_queue.md
# instr_fetch_queue

Decoupling queue between the program counter / instruction-memory fetch stage and the decode stage of the ARM (LEGv8) datapath. Holds up to DEPTH fetched {PC, instruction} pairs so that decode stalls do not force the PC to recompute, and discards all in-flight entries on a taken branch or PC-from-register redirect. Emits back-pressure (`pc_hold`) that the PC register uses as its write-disable.

## Interface
- DEPTH, 4, number of entries; power of two, ≥ 2
- clk  input  1  system clock, all state updates on rising edge
- reset  input  1  synchronous, active-low; clears queue when 0 at a rising edge
- in_valid  input  1  fetch stage presents a valid pair
- in_ready  output  1  queue accepts a pair this cycle
- in_pc  input  64  address of fetched instruction
- in_instr  input  32  fetched instruction word
- out_valid  output  1  decode-side pair valid
- out_ready  input  1  decode consumes the pair this cycle
- out_pc  output  64  PC of head entry
- out_instr  output  32  instruction of head entry
- flush  input  1  redirect (branch taken or PC set from register); discard all entries
- count  output  $clog2(DEPTH)+1  current occupancy
- pc_hold  output  1  equals ~in_ready; PC must not advance

## Operation
- Push: in_valid && in_ready at a rising edge writes {in_pc, in_instr} at write pointer, wptr+1.
- Pop: out_valid && out_ready at a rising edge advances read pointer, rptr+1.
- Pointers are $clog2(DEPTH) bits and wrap naturally from DEPTH-1 to 0.
- in_ready = (count < DEPTH); no pop-through when full (a full queue refuses push even if out_ready is 1).
- out_valid = (count != 0); out_pc/out_instr = head entry when valid.
- When out_valid is 0: out_pc = 64'h0, out_instr = 32'hD503201F (NOP).
- Simultaneous push and pop: both occur, count unchanged.
- Flush: highest priority after reset. wptr, rptr, count cleared; any push and pop that cycle are discarded. in_ready stays asserted during flush (pair is dropped, not stalled).
- Reset (reset == 0): same clearing as flush; overrides everything. Mid-operation reset drops all entries.
- Storage contents are not cleared by reset/flush; only pointers/count.

## Timing
- Reset values: out_valid 0, out_pc 0, out_instr 32'hD503201F, count 0, in_ready 1, pc_hold 0.
- Push-to-output latency: 1 cycle (pair pushed at edge N is visible with out_valid=1 after edge N).
- in_ready, pc_hold, out_valid and count are functions of registered state only (no combinational path from in_valid/out_ready), except as stated under Configuration.
- Flush at edge N: out_valid 0 and count 0 after edge N; first post-flush push at edge N+1 earliest.

## Configuration
- INSTR_FETCH_QUEUE_BYPASS_EN defined: when count == 0, in_valid == 1 and flush == 0, out_valid is asserted combinationally with out_pc = in_pc, out_instr = in_instr; if out_ready is also 1, the pair is consumed without being written (count stays 0). If out_ready is 0, the pair is written normally. Zero-cycle latency on an empty queue.
- Undefined: no combinational in→out path; 1-cycle latency always.

## Structure
- Shared package `fetch_pkg`: typedef struct packed fetch_entry_t {logic [63:0] pc; logic [31:0] instr;}; localparam NOP_INSTR = 32'hD503201F.
- One sub-module `fetchq_storage`: DEPTH × fetch_entry_t register array, one synchronous write port, one asynchronous read port. Pointer/count control stays in the top.

## Test plan
- Reset then push PCs 0x0,0x4,0x8,0xC with out_ready=0 -> count 4, in_ready 0, pc_hold 1; fifth in_valid ignored.
- Drain the above with out_ready=1 -> out_pc 0x0,0x4,0x8,0xC on consecutive cycles, then out_valid 0, out_instr 0xD503201F.
- Continuous push+pop for 10 cycles starting at PC 0x100 -> count constant at 1, outputs 0x100..0x124 in order across pointer wrap.
- Queue holding 3 entries, flush=1 with in_valid=1 PC 0x40 -> count 0, out_valid 0 next cycle; PC 0x40 not delivered.
- reset=0 asserted while count=2 -> all outputs at reset values next cycle; deassert and push 0x200 -> delivered after one cycle (after zero cycles with INSTR_FETCH_QUEUE_BYPASS_EN).
